// File: rtl/vector_check_sequencer.sv
// Vector check sequencer: drives LFSR-generated {x,y} stimulus to a reference
// unit and a unit under check, compares their responses one vector at a time,
// and records the mismatch count, the first mismatching index and a sticky flag.
module vector_check_sequencer #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] num_vec,
    output logic       x,
    output logic       y,
    input  logic       z_ref,
    input  logic       z_dut,
    output logic       busy,
    output logic       done,
    output logic [7:0] err_count,
    output logic [7:0] first_err,
    output logic       any_err
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] num_vec_q, num_vec_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] idx_q, idx_d;
    logic       x_q, x_d;
    logic       y_q, y_d;
    logic [7:0] err_count_q, err_count_d;
    logic [7:0] first_err_q, first_err_d;
    logic       any_err_q, any_err_d;

    // Next-state and datapath updates; every register holds unless its state acts on it
    always_comb begin
        state_d     = state_q;
        num_vec_d   = num_vec_q;
        lfsr_d      = lfsr_q;
        idx_d       = idx_q;
        x_d         = x_q;
        y_d         = y_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        any_err_d   = any_err_q;

        case (state_q)
            IDLE: begin
                if (start && (num_vec != 8'd0)) begin
                    state_d     = DRIVE;
                    num_vec_d   = num_vec;
                    lfsr_d      = SEED;
                    idx_d       = '0;
                    err_count_d = '0;
                    first_err_d = '1;
                    any_err_d   = 1'b0;
                end
            end
            DRIVE: begin
                x_d     = lfsr_q[1];
                y_d     = lfsr_q[0];
                state_d = SAMPLE;
            end
            SAMPLE: begin
                if (z_dut != z_ref) begin
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                    // first_err is captured only while the sticky flag is still clear
                    if (!any_err_q) begin
                        first_err_d = idx_q;
                    end
                    any_err_d = 1'b1;
                end
                lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                if (idx_q == num_vec_q - 8'd1) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = DRIVE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            num_vec_q   <= '0;
            lfsr_q      <= '0;
            idx_q       <= '0;
            x_q         <= 1'b0;
            y_q         <= 1'b0;
            err_count_q <= '0;
            first_err_q <= '1;
            any_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_vec_q   <= num_vec_d;
            lfsr_q      <= lfsr_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            y_q         <= y_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            any_err_q   <= any_err_d;
        end
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy = (state_q == DRIVE) || (state_q == SAMPLE);
        done = (state_q == DONE);
    end

    assign x         = x_q;
    assign y         = y_q;
    assign err_count = err_count_q;
    assign first_err = first_err_q;
    assign any_err   = any_err_q;

endmodule

// File: doc/vector_check_sequencer.md
VECTOR_CHECK_SEQUENCER -- requirements
Module: vector_check_sequencer

Interface
REQ-001 SHALL have parameter SEED, default 8'hA5, LFSR load value at each run start; any nonzero value is legal.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-005 SHALL have port num_vec  input  8  number of vectors in the run; latched when start is accepted.
REQ-006 SHALL have port x  output  1  registered stimulus bit to both checked units.
REQ-007 SHALL have port y  output  1  registered stimulus bit to both checked units.
REQ-008 SHALL have port z_ref  input  1  combinational response of the reference unit to x,y.
REQ-009 SHALL have port z_dut  input  1  combinational response of the unit under check to x,y.
REQ-010 SHALL have port busy  output  1  high in DRIVE and SAMPLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse in DONE.
REQ-012 SHALL have port err_count  output  8  mismatch count for the current or last run, saturating at 255.
REQ-013 SHALL have port first_err  output  8  vector index of the first mismatch; 8'hFF if none.
REQ-014 SHALL have port any_err  output  1  high once any mismatch is seen in the current or last run.

Function
REQ-015 SHALL implement the states IDLE, DRIVE, SAMPLE and DONE, encoded one state per cycle.
REQ-016 IDLE: when start=1 and num_vec!=0, SHALL go to DRIVE, latch num_vec, load the LFSR with SEED, clear idx, err_count and any_err, and set first_err=8'hFF.
REQ-017 IDLE: start=1 with num_vec=0 SHALL be ignored, with no state change and no done pulse.
REQ-018 start SHALL be ignored outside IDLE; an in-flight run is never restarted.
REQ-019 DRIVE lasts exactly one cycle and SHALL register {x,y} <= lfsr[1:0], then go to SAMPLE.
REQ-020 SAMPLE lasts exactly one cycle and SHALL compare z_ref against z_dut while x,y are held stable.
REQ-021 A mismatch in SAMPLE (z_dut!=z_ref) SHALL increment err_count, saturating at 255, and set any_err.
REQ-022 The first mismatch of a run SHALL load first_err with idx; later mismatches SHALL NOT change first_err.
REQ-023 SAMPLE SHALL advance the LFSR by one step: left shift, bit0 <= b7^b5^b4^b3.
REQ-024 SAMPLE SHALL go to DONE when idx==num_vec_latched-1; otherwise it SHALL increment idx and go to DRIVE.
REQ-025 Each vector SHALL take 2 cycles; for a start sampled at edge 0, done SHALL be high during the cycle after edge 2N.
REQ-026 DONE SHALL assert done for one cycle and then go to IDLE.
REQ-027 x, y, err_count, first_err and any_err SHALL hold their values in IDLE and DONE until the next accepted start.
REQ-028 busy SHALL be combinationally derived from the state, low in IDLE and DONE.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE and set x=0, y=0, busy=0, done=0, err_count=0, any_err=0, first_err=8'hFF and idx=0, and SHALL clear the latched num_vec and the LFSR to 0.
REQ-030 Reset SHALL take priority over start and over every state transition, including mid-run; no done pulse follows an aborted run.

Verification
REQ-031 Tie z_dut=z_ref, SEED=8'hA5, num_vec=10, pulse start -> first {x,y}=01, second {x,y}=10, done pulses once 20 cycles after start, err_count=0, any_err=0, first_err=8'hFF.
REQ-032 z_dut=~z_ref only while idx==3, num_vec=8 -> err_count=1, first_err=3, any_err=1 after done.
REQ-033 z_dut=~z_ref always, num_vec=255, then a second run with num_vec=255 -> err_count=255 after each run, first_err=0, and counters cleared at the second start.
REQ-034 start with num_vec=0 -> busy stays 0 and no done pulse; a start pulse during busy -> the run still ends after its original count.
REQ-035 Assert reset in the SAMPLE of idx=4 with a mismatch present -> next cycle IDLE, err_count=0, first_err=8'hFF, x=y=0, and no done pulse.
